// File: rtl/lr3_seg_pkg.sv
// lr3_seg_pkg: shared definitions for the lr3 7-segment scanner.
//   state_t      : scanner FSM states (S_OFF, S_GUARD, S_ON)
//   SEG_OFF      : all segments dark (active-low)
//   SEG_HEX_0..F : active-low {g,f,e,d,c,b,a} patterns for hex digits
package lr3_seg_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_GUARD = 2'd1,
    S_ON    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF   = 7'h7F;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/lr3_hex7seg.sv
// lr3_hex7seg: combinational hex nibble to active-low 7-segment decoder.
//   nib : 4-bit hex value
//   seg : active-low segments {g,f,e,d,c,b,a}
module lr3_hex7seg
  import lr3_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for the nibble.
  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0:    seg = SEG_HEX_0;
      4'h1:    seg = SEG_HEX_1;
      4'h2:    seg = SEG_HEX_2;
      4'h3:    seg = SEG_HEX_3;
      4'h4:    seg = SEG_HEX_4;
      4'h5:    seg = SEG_HEX_5;
      4'h6:    seg = SEG_HEX_6;
      4'h7:    seg = SEG_HEX_7;
      4'h8:    seg = SEG_HEX_8;
      4'h9:    seg = SEG_HEX_9;
      4'hA:    seg = SEG_HEX_A;
      4'hB:    seg = SEG_HEX_B;
      4'hC:    seg = SEG_HEX_C;
      4'hD:    seg = SEG_HEX_D;
      4'hE:    seg = SEG_HEX_E;
      4'hF:    seg = SEG_HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/lr3_seg_scan.sv
// lr3_seg_scan: dynamic multiplexer for a common-anode N_DIG-digit 7-segment
// display. Each CE tick advances one digit, with GUARD_CYC all-dark cycles in
// between; display data is snapshotted once per frame (at digit 0).
// Optional build macro LR3_SEG_LZB_EN enables leading-zero blanking.
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   CE       : one-cycle scan tick
//   DATA     : hex nibbles, digit k = DATA[4k+3:4k]
//   DP_IN    : decimal point request per digit (1 = lit)
//   EN_DIG   : digit enable mask (0 = always dark)
//   AN       : anode drives, active-low
//   SEG      : segments {g..a}, active-low
//   DP       : decimal point, active-low
//   FRAME    : one-cycle pulse when a new frame (digit 0) starts
module lr3_seg_scan
  import lr3_seg_pkg::*;
#(
  parameter  int N_DIG     = 8,
  parameter  int GUARD_CYC = 2,
  localparam int IDX_W     = $clog2(N_DIG)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic [4*N_DIG-1:0] DATA,
  input  logic [N_DIG-1:0]   DP_IN,
  input  logic [N_DIG-1:0]   EN_DIG,
  output logic [N_DIG-1:0]   AN,
  output logic [6:0]         SEG,
  output logic               DP,
  output logic               FRAME
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
  localparam logic [3:0]       GUARD_LD = 4'(GUARD_CYC);
  localparam bit               NO_GUARD = (GUARD_CYC == 0);
  localparam state_t           ST_ADV   = NO_GUARD ? S_ON : S_GUARD;
  localparam logic [3:0]       CNT_ADV  = NO_GUARD ? 4'd0 : GUARD_LD;

  state_t               state_r, state_s;
  logic [IDX_W-1:0]     idx_r, idx_s;
  logic [3:0]           cnt_r, cnt_s;
  logic [4*N_DIG-1:0]   snap_data_r, view_data_s;
  logic [N_DIG-1:0]     snap_en_r, snap_dp_r;
  logic [N_DIG-1:0]     view_en_s, view_dp_s, keep_s, an_s;
  logic                 take_snap_s;
  logic [3:0]           nib_s;
  logic                 dp_bit_s;
  logic [6:0]           seg_dec_s;

`ifdef LR3_SEG_LZB_EN
  logic lead_s;

  // Leading-zero blanking: a digit stays lit unless it and every digit above
  // it are zero; digit 0 is always kept.
  always_comb begin
    keep_s = '1;
    lead_s = 1'b1;
    for (int k = N_DIG - 1; k >= 1; k--) begin
      lead_s    = lead_s & (DATA[4*k +: 4] == 4'h0);
      keep_s[k] = ~lead_s;
    end
  end
`else
  assign keep_s = '1;
`endif

  // Next state, next digit index, guard counter and snapshot request.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    take_snap_s = 1'b0;
    case (state_r)
      S_OFF: begin
        if (CE) begin
          idx_s       = '0;
          take_snap_s = 1'b1;
          state_s     = ST_ADV;
          cnt_s       = CNT_ADV;
        end else begin
          state_s = S_OFF;
        end
      end
      S_ON: begin
        if (CE) begin
          state_s = ST_ADV;
          cnt_s   = CNT_ADV;
          // Explicit wrap keeps the index below N_DIG for any digit count.
          if (idx_r == IDX_LAST) begin
            idx_s       = '0;
            take_snap_s = 1'b1;
          end else begin
            idx_s = idx_r + IDX_W'(1);
          end
        end else begin
          state_s = S_ON;
        end
      end
      S_GUARD: begin
        // CE is deliberately ignored here; the counter alone ends the guard.
        if (cnt_r <= 4'd1) begin
          state_s = S_ON;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = S_OFF;
        idx_s   = '0;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Data visible after this edge: a fresh snapshot when one is taken,
  // otherwise the held one. Blanked digits also lose their decimal point.
  always_comb begin
    if (take_snap_s) begin
      view_data_s = DATA;
      view_en_s   = EN_DIG & keep_s;
      view_dp_s   = DP_IN & keep_s;
    end else begin
      view_data_s = snap_data_r;
      view_en_s   = snap_en_r;
      view_dp_s   = snap_dp_r;
    end
  end

  // Select the nibble / DP of the next digit and build a one-hot-low anode.
  always_comb begin
    nib_s    = 4'h0;
    dp_bit_s = 1'b0;
    an_s     = '1;
    for (int k = 0; k < N_DIG; k++) begin
      nib_s    = (idx_s == IDX_W'(k)) ? view_data_s[4*k +: 4] : nib_s;
      dp_bit_s = (idx_s == IDX_W'(k)) ? view_dp_s[k] : dp_bit_s;
      an_s[k]  = ~((idx_s == IDX_W'(k)) & view_en_s[k]);
    end
  end

  lr3_hex7seg u_dec (
    .nib (nib_s),
    .seg (seg_dec_s)
  );

  // Scanner state and registered display outputs, updated on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= S_OFF;
      idx_r       <= '0;
      cnt_r       <= 4'd0;
      snap_data_r <= '0;
      snap_en_r   <= '0;
      snap_dp_r   <= '0;
      AN          <= '1;
      SEG         <= SEG_OFF;
      DP          <= 1'b1;
      FRAME       <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      cnt_r       <= cnt_s;
      snap_data_r <= view_data_s;
      snap_en_r   <= view_en_s;
      snap_dp_r   <= view_dp_s;
      FRAME       <= take_snap_s;
      if (state_s == S_ON) begin
        AN  <= an_s;
        SEG <= seg_dec_s;
        DP  <= ~dp_bit_s;
      end else begin
        AN  <= '1;
        SEG <= SEG_OFF;
        DP  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lr3_seg_scan.sv
// tb_lr3_seg_scan: scoreboard bench for lr3_seg_scan (N_DIG=4, GUARD_CYC=2).
// Stimulus pushes the expected sequence of distinct output states; a monitor
// pops one entry each time {AN,SEG,DP,FRAME} changes and compares it.
module tb_lr3_seg_scan;

`ifdef LR3_SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        CE;
  logic [15:0] DATA;
  logic [3:0]  DP_IN;
  logic [3:0]  EN_DIG;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        FRAME;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
    int         dur;    // expected cycles this state lasts, 0 = unchecked
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_on = 1'b0;

  lr3_seg_scan #(.N_DIG(4), .GUARD_CYC(2)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .CE     (CE),
    .DATA   (DATA),
    .DP_IN  (DP_IN),
    .EN_DIG (EN_DIG),
    .AN     (AN),
    .SEG    (SEG),
    .DP     (DP),
    .FRAME  (FRAME)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t mk(input logic [3:0] an, input logic [6:0] seg,
                              input logic dp, input logic fr, input int dur);
    exp_t e;
    e.an = an; e.seg = seg; e.dp = dp; e.frame = fr; e.dur = dur;
    return e;
  endfunction

  // Anode pattern of a digit that leading-zero blanking would darken.
  function automatic logic [3:0] lz(input logic [3:0] an);
    return LZB ? 4'hF : an;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic ce_pulse(input int len);
    @(posedge CLK); #1 CE = 1'b1;
    repeat (len) @(posedge CLK);
    #1 CE = 1'b0;
  endtask

  // One scan step: expected dark guard (with FRAME on a new frame), then the lit digit.
  task automatic step(input bit fr, input logic [3:0] an, input logic [6:0] seg,
                      input logic dp, input int len);
    if (fr) begin
      q.push_back(mk(4'hF, 7'h7F, 1'b1, 1'b1, 1));
      q.push_back(mk(4'hF, 7'h7F, 1'b1, 1'b0, 1));
    end else begin
      q.push_back(mk(4'hF, 7'h7F, 1'b1, 1'b0, 2));
    end
    q.push_back(mk(an, seg, dp, 1'b0, 0));
    ce_pulse(len);
    repeat (19 - len) @(posedge CLK);
  endtask

  // Monitor: on every change of the output tuple, check how long the previous
  // state lasted and compare the new state with the head of the queue.
  logic [12:0] prev = {4'hF, 7'h7F, 1'b1, 1'b0};
  exp_t        cur_e;
  bit          have = 1'b0;
  int          run  = 0;

  always @(negedge CLK) begin
    if (mon_on) begin
      if ({AN, SEG, DP, FRAME} !== prev) begin
        if (have && cur_e.dur != 0)
          chk("hold_cycles", 16'(run), 16'(cur_e.dur));
        if (q.size() == 0) begin
          total++;
          bad++;
          have = 1'b0;
          $display("FAIL unexpected_change actual=%b required=no_change", {AN, SEG, DP, FRAME});
        end else begin
          cur_e = q.pop_front();
          have  = 1'b1;
          chk("outputs", {3'b000, AN, SEG, DP, FRAME},
              {3'b000, cur_e.an, cur_e.seg, cur_e.dp, cur_e.frame});
        end
        prev = {AN, SEG, DP, FRAME};
        run  = 1;
      end else begin
        run++;
      end
    end
  end

  initial begin
    RST = 1'b1; CE = 1'b0; DATA = 16'h0000; DP_IN = 4'h0; EN_DIG = 4'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_an",    {12'h000, AN},    16'h000F);
    chk("rst_seg",   {9'h000, SEG},    16'h007F);
    chk("rst_dp_fr", {14'h0000, DP, FRAME}, 16'h0002);
    @(posedge CLK); #1 RST = 1'b0;
    mon_on = 1'b1;
    repeat (5) @(posedge CLK);

    // Scenarios 1-3: first frame, digit sequence, data change mid-frame.
    DATA = 16'h12AF; EN_DIG = 4'hF; DP_IN = 4'h0;
    step(1'b1, 4'b1110, 7'b0001110, 1'b1, 1);   // F
    step(1'b0, 4'b1101, 7'b0001000, 1'b1, 1);   // A
    step(1'b0, 4'b1011, 7'b0100100, 1'b1, 1);   // 2
    DATA = 16'h0008;
    step(1'b0, 4'b0111, 7'b1111001, 1'b1, 1);   // 1 (old snapshot)
    step(1'b1, 4'b1110, 7'b0000000, 1'b1, 1);   // 8 (new frame)
    step(1'b0, lz(4'b1101), 7'b1000000, 1'b1, 2); // CE held over guard: one advance

    // Scenario 4: enable / DP mask take effect only from the next frame.
    EN_DIG = 4'b1011; DP_IN = 4'b0010; DATA = 16'h3210;
    step(1'b0, lz(4'b1011), 7'b1000000, 1'b1, 1);
    step(1'b0, lz(4'b0111), 7'b1000000, 1'b1, 1);
    step(1'b1, 4'b1110, 7'b1000000, 1'b1, 1);   // 0
    step(1'b0, 4'b1101, 7'b1111001, 1'b0, 1);   // 1 with DP
    step(1'b0, 4'b1111, 7'b0100100, 1'b1, 1);   // 2, disabled slot
    step(1'b0, 4'b0111, 7'b0110000, 1'b1, 1);   // 3

    // Scenario 5a: reset during guard.
    q.push_back(mk(4'hF, 7'h7F, 1'b1, 1'b1, 1));
    q.push_back(mk(4'hF, 7'h7F, 1'b1, 1'b0, 0));
    ce_pulse(1);
    @(posedge CLK); #1 RST = 1'b1;
    #1 chk("rst_guard", {3'b000, AN, SEG, DP, FRAME}, {3'b000, 4'hF, 7'h7F, 1'b1, 1'b0});
    repeat (3) @(posedge CLK); #1 RST = 1'b0;
    repeat (10) @(posedge CLK);
    DATA = 16'h12AF; EN_DIG = 4'hF; DP_IN = 4'h0;
    step(1'b1, 4'b1110, 7'b0001110, 1'b1, 1);   // restart at digit 0

    // Scenario 5b: reset while a digit is lit.
    q.push_back(mk(4'hF, 7'h7F, 1'b1, 1'b0, 0));
    @(posedge CLK); #1 RST = 1'b1;
    #1 chk("rst_on", {3'b000, AN, SEG, DP, FRAME}, {3'b000, 4'hF, 7'h7F, 1'b1, 1'b0});
    repeat (3) @(posedge CLK); #1 RST = 1'b0;
    repeat (10) @(posedge CLK);

    // Scenario 6: leading zeros (dark only with blanking compiled in).
    DATA = 16'h0050;
    step(1'b1, 4'b1110, 7'b1000000, 1'b1, 1);   // 0
    step(1'b0, 4'b1101, 7'b0010010, 1'b1, 1);   // 5
    step(1'b0, lz(4'b1011), 7'b1000000, 1'b1, 1);
    step(1'b0, lz(4'b0111), 7'b1000000, 1'b1, 1);
    DATA = 16'h0000; DP_IN = 4'hF;
    step(1'b1, 4'b1110, 7'b1000000, 1'b0, 1);
    step(1'b0, lz(4'b1101), 7'b1000000, LZB, 1);
    step(1'b0, lz(4'b1011), 7'b1000000, LZB, 1);
    step(1'b0, lz(4'b0111), 7'b1000000, LZB, 1);

    repeat (10) @(posedge CLK);
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
